// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle-handshake clock-domain-crossing blocks.
// Synchronizer instances and both protocol ends reset to SYNC_INIT.
package cdc_pkg;

   typedef logic [0:0] state_t;

   localparam state_t IDLE     = 1'b0;
   localparam state_t WAIT_ACK = 1'b1;

   localparam logic SYNC_INIT = 1'b0;

   // A handshake is complete once the returned toggle equals the one sent.
   function automatic logic toggle_match(input logic ack, input logic req);
      return (ack == req);
   endfunction

endpackage

// File: rtl/updown_sat_counter.sv
// Up/down counter that holds at zero and at all-ones.
// Simultaneous inc and dec leave the value unchanged.
module updown_sat_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] value,
   output logic             sat
);

   localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1'b1);

   logic [WIDTH-1:0] value_r;
   logic [WIDTH-1:0] value_nxt_s;

   // Next count with saturation at both ends.
   always_comb begin
      value_nxt_s = value_r;
      if (inc && !dec && (value_r != MAX_VAL)) begin
         value_nxt_s = value_r + ONE_VAL;
      end else if (dec && !inc && (value_r != ZERO_VAL)) begin
         value_nxt_s = value_r - ONE_VAL;
      end else begin
         value_nxt_s = value_r;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value_r <= ZERO_VAL;
      end else begin
         value_r <= value_nxt_s;
      end
   end

   assign value = value_r;
   assign sat   = (value_r == MAX_VAL);

endmodule

// File: rtl/cdc_toggle_sender.sv
// Source end of the toggle-handshake CDC: each event pulse becomes one
// req_toggle transition; events arriving mid-handshake queue in a saturating count.
module cdc_toggle_sender
   import cdc_pkg::*;
#(
   parameter int PENDING_WIDTH  = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     pulse_in,
   input  logic                     ack_toggle,
   input  logic                     clear_err,
   output logic                     req_toggle,
   output logic                     busy,
   output logic [PENDING_WIDTH-1:0] pending,
   output logic                     overflow,
   output logic                     timeout
);

   localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
   localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1'b1);
   localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMEOUT_CYCLES);
   localparam logic [TIMER_W-1:0] TIMER_LAST =
      TIMER_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
   localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic                   req_toggle_r;
   logic                   overflow_r;
   logic                   timeout_r;
   logic [TIMER_W-1:0]     timer_r;
   logic [PENDING_WIDTH-1:0] pending_s;
   logic                   sat_s;

   logic match_s;
   logic pend_nz_s;
   logic launch_s;
   logic direct_s;
   logic accept_s;
   logic dec_s;
   logic drop_s;
   logic counting_s;
   logic timeout_set_s;
   logic busy_s;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state: a launch always (re)enters WAIT_ACK, a bare match retires.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (launch_s) begin
               state_nxt_s = WAIT_ACK;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT_ACK: begin
            if (launch_s) begin
               state_nxt_s = WAIT_ACK;
            end else if (match_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = WAIT_ACK;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM outputs and event bookkeeping decodes.
   always_comb begin
      match_s       = toggle_match(ack_toggle, req_toggle_r);
      pend_nz_s     = (pending_s != {PENDING_WIDTH{1'b0}});
      busy_s        = 1'b0;
      launch_s      = 1'b0;
      counting_s    = 1'b0;
      case (state_r)
         IDLE: begin
            busy_s   = 1'b0;
            launch_s = pend_nz_s || pulse_in;
         end
         WAIT_ACK: begin
            busy_s     = 1'b1;
            launch_s   = match_s && (pend_nz_s || pulse_in);
            counting_s = !match_s;
         end
         default: begin
            busy_s   = 1'b0;
            launch_s = 1'b0;
         end
      endcase
      // Queued events go first; the live pulse is only used when nothing waits.
      direct_s      = launch_s && !pend_nz_s;
      dec_s         = launch_s && pend_nz_s;
      accept_s      = pulse_in && !direct_s;
      drop_s        = accept_s && sat_s && !dec_s;
      timeout_set_s = TIMEOUT_EN && counting_s && (timer_r == TIMER_LAST);
   end

   updown_sat_counter #(
      .WIDTH (PENDING_WIDTH)
   ) u_pending (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (accept_s),
      .dec   (dec_s),
      .value (pending_s),
      .sat   (sat_s)
   );

   // Request toggle: one transition per launched event.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_toggle_r <= SYNC_INIT;
      end else if (launch_s) begin
         req_toggle_r <= !req_toggle_r;
      end else begin
         req_toggle_r <= req_toggle_r;
      end
   end

   // Acknowledge timer; saturates so the flag fires once per late handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer_r <= TIMER_ZERO;
      end else if (launch_s) begin
         timer_r <= TIMER_ZERO;
      end else if (TIMEOUT_EN && counting_s && (timer_r != TIMER_MAX)) begin
         timer_r <= timer_r + TIMER_ONE;
      end else begin
         timer_r <= timer_r;
      end
   end

   // Sticky error flags; a new error beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow_r <= 1'b0;
         timeout_r  <= 1'b0;
      end else begin
         if (drop_s) begin
            overflow_r <= 1'b1;
         end else if (clear_err) begin
            overflow_r <= 1'b0;
         end else begin
            overflow_r <= overflow_r;
         end
         if (timeout_set_s) begin
            timeout_r <= 1'b1;
         end else if (clear_err) begin
            timeout_r <= 1'b0;
         end else begin
            timeout_r <= timeout_r;
         end
      end
   end

   assign req_toggle = req_toggle_r;
   assign busy       = busy_s;
   assign pending    = pending_s;
   assign overflow   = overflow_r;
   assign timeout    = timeout_r;

endmodule

// File: tb/tb_cdc_toggle_sender.sv
// Bench for cdc_toggle_sender: two instances (deep queue with timeout, shallow
// queue without) share stimulus, each with its own far-end responder and model.
module tb_cdc_toggle_sender;

   logic       clk;
   logic       rst_n;
   logic       pulse_in;
   logic       clear_err;
   logic       hold;
   logic       ack_a, ack_b;
   logic       req_a, req_b, busy_a, busy_b;
   logic [3:0] pend_a;
   logic [1:0] pend_b;
   logic       ovf_a, ovf_b, to_a, to_b;
   logic [4:0] hist_a, hist_b;

   int  n_checks = 0;
   int  n_pass   = 0;
   bit  cmp_en   = 1'b0;
   int  launches_a = 0, launches_b = 0;
   logic prev_a = 1'b0, prev_b = 1'b0;
   int  base_a, base_b;

   typedef struct packed {
      bit req;
      bit busy;
      int pend;
      bit ovf;
      bit to;
      int timer;
   } model_t;

   model_t ma = '0;
   model_t mb = '0;

   cdc_toggle_sender #(.PENDING_WIDTH(4), .TIMEOUT_CYCLES(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .ack_toggle(ack_a),
      .clear_err(clear_err), .req_toggle(req_a), .busy(busy_a),
      .pending(pend_a), .overflow(ovf_a), .timeout(to_a)
   );

   cdc_toggle_sender #(.PENDING_WIDTH(2), .TIMEOUT_CYCLES(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .ack_toggle(ack_b),
      .clear_err(clear_err), .req_toggle(req_b), .busy(busy_b),
      .pending(pend_b), .overflow(ovf_b), .timeout(to_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Far end: echoes req back 6 cycles later; hold freezes the echo.
   always @(posedge clk) begin
      if (!rst_n) begin
         hist_a <= 5'd0; hist_b <= 5'd0; ack_a <= 1'b0; ack_b <= 1'b0;
      end else begin
         hist_a <= {hist_a[3:0], req_a};
         hist_b <= {hist_b[3:0], req_b};
         if (!hold) begin
            ack_a <= hist_a[4];
            ack_b <= hist_b[4];
         end
      end
   end

   // Event-level model: one outstanding request, a bounded queue of waiting events.
   function automatic model_t step(model_t m, bit pulse, bit ack, bit clr, bit rstn,
                                   int pmax, int tmo);
      model_t n;
      bit direct, set_o, set_t;
      n = m; direct = 1'b0; set_o = 1'b0; set_t = 1'b0;
      if (!rstn) return '0;
      if ((!m.busy || ack == m.req) && (m.pend > 0 || pulse)) begin
         n.req = !m.req; n.busy = 1'b1; n.timer = 0;
         if (m.pend > 0) n.pend = m.pend - 1;
         else direct = 1'b1;
      end else if (m.busy && ack == m.req) begin
         n.busy = 1'b0;
      end else if (m.busy && tmo > 0 && m.timer < tmo) begin
         n.timer = m.timer + 1;
         if (n.timer == tmo) set_t = 1'b1;
      end
      if (pulse && !direct) begin
         if (n.pend < pmax) n.pend = n.pend + 1;
         else set_o = 1'b1;
      end
      n.ovf = set_o ? 1'b1 : (clr ? 1'b0 : m.ovf);
      n.to  = set_t ? 1'b1 : (clr ? 1'b0 : m.to);
      return n;
   endfunction

   always @(posedge clk) begin
      ma <= step(ma, pulse_in, ack_a, clear_err, rst_n, 15, 8);
      mb <= step(mb, pulse_in, ack_b, clear_err, rst_n, 3, 0);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("a.req", int'(req_a), int'(ma.req));
         chk("a.busy", int'(busy_a), int'(ma.busy));
         chk("a.pending", int'(pend_a), ma.pend);
         chk("a.overflow", int'(ovf_a), int'(ma.ovf));
         chk("a.timeout", int'(to_a), int'(ma.to));
         chk("b.req", int'(req_b), int'(mb.req));
         chk("b.busy", int'(busy_b), int'(mb.busy));
         chk("b.pending", int'(pend_b), mb.pend);
         chk("b.overflow", int'(ovf_b), int'(mb.ovf));
         chk("b.timeout", int'(to_b), int'(mb.to));
      end
   end

   // Counts req transitions (launches, plus any reset-induced drop).
   always @(negedge clk) begin
      prev_a <= req_a;
      prev_b <= req_b;
      launches_a <= launches_a + ((req_a != prev_a) ? 1 : 0);
      launches_b <= launches_b + ((req_b != prev_b) ? 1 : 0);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (!busy_a && !busy_b && pend_a == 4'd0 && pend_b == 2'd0) begin
            ok = 1'b1;
            break;
         end
         cyc(1);
      end
      chk(name, int'(ok), 1);
   endtask

   task automatic pulse_clear();
      clear_err = 1'b1; cyc(1); clear_err = 1'b0;
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0; pulse_in = 1'b0; clear_err = 1'b0; hold = 1'b0;
      cyc(1);
      cmp_en = 1'b1;
      cyc(1);
      rst_n = 1'b1;
      chk("reset.req", int'(req_a), 0);
      chk("reset.busy", int'(busy_a), 0);
      chk("reset.pending", int'(pend_a), 0);
      chk("reset.flags", int'({ovf_a, to_a, ovf_b, to_b}), 0);

      // Single event
      pulse_in = 1'b1; cyc(1); pulse_in = 1'b0;
      chk("single.req", int'(req_a), 1);
      chk("single.busy", int'(busy_a), 1);
      chk("single.pending", int'(pend_a), 0);
      cnt = 1;
      for (int i = 0; i < 20 && busy_a; i++) begin
         cyc(1);
         if (busy_a) cnt++;
      end
      chk("single.busy_cycles", cnt, 7);
      chk("single.pending_end", int'(pend_a), 0);

      // Burst of five
      base_a = launches_a; base_b = launches_b;
      pulse_in = 1'b1; cyc(5); pulse_in = 1'b0;
      chk("burst.pending_peak", int'(pend_a), 4);
      chk("burst.a_overflow", int'(ovf_a), 0);
      chk("burst.b_pending", int'(pend_b), 3);
      chk("burst.b_overflow", int'(ovf_b), 1);
      wait_idle("burst.idle", 200);
      chk("burst.a_launches", launches_a - base_a, 5);
      chk("burst.b_launches", launches_b - base_b, 4);
      pulse_clear();
      chk("burst.b_overflow_clr", int'(ovf_b), 0);

      // Overflow with ack withheld
      hold = 1'b1;
      base_a = launches_a; base_b = launches_b;
      pulse_in = 1'b1; cyc(5); pulse_in = 1'b0;
      chk("ovf.b_pending", int'(pend_b), 3);
      chk("ovf.b_overflow", int'(ovf_b), 1);
      cyc(3);
      chk("ovf.b_pending_held", int'(pend_b), 3);
      hold = 1'b0;
      wait_idle("ovf.idle", 300);
      chk("ovf.b_launches", launches_b - base_b, 4);
      chk("ovf.a_launches", launches_a - base_a, 5);
      pulse_clear();
      chk("ovf.flags_clr", int'({ovf_a, to_a, ovf_b, to_b}), 0);

      // Timeout with ack withheld
      hold = 1'b1;
      pulse_in = 1'b1; cyc(1); pulse_in = 1'b0;
      cyc(7);
      chk("tmo.before", int'(to_a), 0);
      cyc(1);
      chk("tmo.set", int'(to_a), 1);
      chk("tmo.busy", int'(busy_a), 1);
      chk("tmo.b_disabled", int'(to_b), 0);
      cyc(20);
      chk("tmo.still_busy", int'(busy_a), 1);
      hold = 1'b0;
      wait_idle("tmo.retire", 100);
      chk("tmo.sticky", int'(to_a), 1);
      pulse_clear();
      chk("tmo.cleared", int'(to_a), 0);
      hold = 1'b1;
      pulse_in = 1'b1; cyc(1); pulse_in = 1'b0;
      cyc(7);
      chk("tmo2.before", int'(to_a), 0);
      clear_err = 1'b1; cyc(1); clear_err = 1'b0;
      chk("tmo2.set_beats_clear", int'(to_a), 1);
      hold = 1'b0;
      wait_idle("tmo2.retire", 100);
      pulse_clear();

      // Reset mid-handshake
      hold = 1'b1;
      pulse_in = 1'b1; cyc(3); pulse_in = 1'b0;
      chk("rst.pending_a", int'(pend_a), 2);
      chk("rst.pending_b", int'(pend_b), 2);
      rst_n = 1'b0; cyc(1); rst_n = 1'b1; hold = 1'b0;
      chk("rst.outputs_a", int'({req_a, busy_a, pend_a, ovf_a, to_a}), 0);
      chk("rst.outputs_b", int'({req_b, busy_b, pend_b, ovf_b, to_b}), 0);
      cyc(1);
      base_a = launches_a; base_b = launches_b;
      cyc(40);
      chk("rst.no_launch_a", launches_a - base_a, 0);
      chk("rst.no_launch_b", launches_b - base_b, 0);

      // Pulse coinciding with match, nothing queued
      pulse_in = 1'b1; cyc(1); pulse_in = 1'b0;
      cyc(6);
      chk("relaunch.req_before", int'(req_a), 1);
      chk("relaunch.busy_before", int'(busy_a), 1);
      pulse_in = 1'b1; cyc(1); pulse_in = 1'b0;
      chk("relaunch.req", int'(req_a), 0);
      chk("relaunch.busy", int'(busy_a), 1);
      chk("relaunch.pending", int'(pend_a), 0);
      wait_idle("relaunch.idle", 100);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
